// File: rtl/reg_file_banked.sv
// Banked register file: windowed rs/rt read ports, windowed rd write port,
// write handshake with optional bypass, bulk-clear engine and sticky range error.
module reg_file_banked #(
    parameter int NUM_REG   = 12,
    parameter int REG_WIDTH = 8,
    parameter int RS_AW     = 3,
    parameter int RT_AW     = 3,
    parameter int RD_AW     = 2,
    parameter int RS_BASE   = 0,
    parameter int RT_BASE   = 4,
    parameter int RD_BASE   = 8,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RS_AW-1:0]     rs_addr,
    input  logic [RT_AW-1:0]     rt_addr,
    output logic [REG_WIDTH-1:0] rs_out,
    output logic [REG_WIDTH-1:0] rt_out,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [RD_AW-1:0]     rd_addr,
    input  logic [REG_WIDTH-1:0] wr_data,
    input  logic                 clr_start,
    output logic                 busy,
    output logic                 clr_done,
    output logic                 err
);

    localparam int AW = $clog2(NUM_REG) + 1;
    localparam int PW = $clog2(NUM_REG);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t state, state_nx;

    logic [REG_WIDTH-1:0] regs [NUM_REG];
    logic [PW-1:0]        ptr;
    logic [AW-1:0]        rs_phys, rt_phys, wr_phys;
    logic                 rs_oor, rt_oor, wr_oor;
    logic                 wr_fire, wr_en;
    logic                 clr_go, clr_last;
    logic [REG_WIDTH-1:0] rs_mem, rt_mem;

    // Physical indices carry one spare bit so base+local never wraps.
    assign rs_phys = AW'(RS_BASE) + AW'(rs_addr);
    assign rt_phys = AW'(RT_BASE) + AW'(rt_addr);
    assign wr_phys = AW'(RD_BASE) + AW'(rd_addr);

    assign rs_oor = rs_phys >= AW'(NUM_REG);
    assign rt_oor = rt_phys >= AW'(NUM_REG);
    assign wr_oor = wr_phys >= AW'(NUM_REG);

    assign busy     = (state == CLEAR);
    assign wr_ready = ~busy;
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_en    = wr_fire && !wr_oor;
    assign clr_go   = (state == IDLE) && clr_start;
    assign clr_last = busy && (ptr == PW'(NUM_REG - 1));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (clr_start) state_nx = CLEAR;
            CLEAR: if (clr_last)  state_nx = IDLE;
        endcase
    end

    // Out-of-range indices match no entry and read as zero.
    always_comb begin
        rs_mem = '0;
        rt_mem = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            if (rs_phys == AW'(i)) rs_mem = regs[i];
            if (rt_phys == AW'(i)) rt_mem = regs[i];
        end
    end

    always_comb begin
        rs_out = rs_mem;
        rt_out = rt_mem;
        if (BYPASS != 0 && wr_en && rs_phys == wr_phys) rs_out = wr_data;
        if (BYPASS != 0 && wr_en && rt_phys == wr_phys) rt_out = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else begin
            for (int i = 0; i < NUM_REG; i++) begin
                if (busy && ptr == PW'(i))
                    regs[i] <= '0;
                else if (wr_en && wr_phys == AW'(i))
                    regs[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            clr_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            clr_done <= clr_last;
            if (clr_go || clr_last)
                ptr <= '0;
            else if (busy)
                ptr <= ptr + PW'(1);
            if (clr_go)
                err <= 1'b0;
            else if (rs_oor || rt_oor || (wr_fire && wr_oor))
                err <= 1'b1;
        end
    end

endmodule
